// File: rtl/greycode_pkg.sv
// greycode_pkg: shared constants, status layout and Gray-code helpers
package greycode_pkg;
  localparam int PRESCALE_BITS = 20;
  localparam int HIST_DEPTH = 8;
  localparam int ERR_MAX = 15;
  typedef logic [7:0] code_t;
  typedef struct packed {
    logic       lock;
    logic [3:0] err_cnt;
    logic [2:0] latency;
  } status_t;
  function automatic code_t bin2gray(code_t b);
    return b ^ (b >> 1);
  endfunction
  function automatic code_t gray2bin(code_t g);
    code_t b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [3:0] popcount8(code_t v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/greycode_if.sv
// greycode_if: TinyTapeout user-slot pins (ena, ui_in, uo_out, uio_in, uio_out, uio_oe)
interface greycode_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/greycode_gray_checker.sv
// gray_checker: syncs returned code, finds its age in output history, counts illegal steps
// ports: clk, rst_n (async low); i_uo current output code; i_ui returned code; o_status {lock, err_cnt, latency}
module gray_checker
  import greycode_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  code_t   i_uo,
  input  code_t   i_ui,
  output status_t o_status
);
  code_t r_s1, r_s2, r_s3;
  code_t r_hist [HIST_DEPTH];
  status_t r_stat;
  logic w_hit;
  logic [2:0] w_k;
  logic w_bad;
  // descending scan so the smallest matching slot wins
  always_comb begin
    w_hit = 1'b0;
    w_k = '0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--)
      if (r_s2 == r_hist[i]) begin
        w_hit = 1'b1;
        w_k = 3'(i);
      end
  end
  assign w_bad = popcount8(r_s2 ^ r_s3) > 4'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
      r_stat <= '0;
    end else begin
      r_s1 <= i_ui;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_hist[0] <= i_uo;
      for (int i = 1; i < HIST_DEPTH; i++) r_hist[i] <= r_hist[i-1];
      r_stat.lock <= w_hit;
      r_stat.latency <= w_k;
      if (w_bad && r_stat.err_cnt != 4'(ERR_MAX)) r_stat.err_cnt <= r_stat.err_cnt + 4'd1;
    end
  assign o_status = r_stat;
endmodule

// File: rtl/greycode_top.sv
// greycode_top: free-running 8-bit Gray-code generator with loop-back checker
// ports: clk, rst_n (async low); bus.ena count enable; bus.ui_in returned code; bus.uo_out Gray code;
//        bus.uio_out status {lock, err_cnt, latency}; bus.uio_oe all outputs; bus.uio_in ignored
module greycode_top
  import greycode_pkg::*;
#(
  parameter bit pTEST = 1'b0
) (
  input logic clk,
  input logic rst_n,
  greycode_if.slave bus
);
  logic [PRESCALE_BITS-1:0] r_pre;
  code_t r_bin, r_uo;
  code_t w_bin_nx;
  status_t w_status;
  logic w_tick;
  logic w_unused;
  assign w_tick = pTEST ? 1'b1 : &r_pre;
  assign w_bin_nx = r_bin + 8'd1;
  // output is loaded with the Gray form of the next count so it tracks bin in the same edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pre <= '0;
      r_bin <= '0;
      r_uo <= '0;
    end else if (bus.ena) begin
      r_pre <= r_pre + PRESCALE_BITS'(1);
      if (w_tick) begin
        r_bin <= w_bin_nx;
        r_uo <= bin2gray(w_bin_nx);
      end
    end
  gray_checker u_chk (
    .clk(clk),
    .rst_n(rst_n),
    .i_uo(r_uo),
    .i_ui(bus.ui_in),
    .o_status(w_status)
  );
  assign bus.uo_out = r_uo;
  assign bus.uio_out = w_status;
  assign bus.uio_oe = 8'hFF;
  assign w_unused = &{1'b0, bus.uio_in};
endmodule

// File: tb/tb_greycode_top.sv
// tb_greycode_top: randomized check of greycode_top against a cycle-history reference model
module tb_greycode_top;
  logic clk = 1'b0;
  logic rst_n;
  greycode_if bus ();
  greycode_top #(.pTEST(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int cmp = 0, mism = 0;
  int t, bcnt, err_m;
  logic [7:0] uo_m [0:4095];
  logic [7:0] ui_m [0:4095];
  logic [7:0] uo_d [0:4095];
  logic [7:0] seq_tab [8];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    if (got !== exp) begin
      mism++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask
  function automatic logic [7:0] uo_at(input int i);
    return i < 0 ? 8'h00 : uo_m[i];
  endfunction
  function automatic logic [7:0] ui_at(input int i);
    return i < 0 ? 8'h00 : ui_m[i];
  endfunction
  // ui_at(j): value present on ui_in at edge j; uo_at(j): output after edge j.
  // Status after edge t judges the value returned at edge t-2 by how many cycles
  // earlier it was first seen on the output, and whether it stepped legally.
  task automatic cyc(input logic [7:0] ui, input logic en);
    logic l;
    int lat;
    bus.ui_in = ui;
    bus.ena = en;
    @(posedge clk);
    #1;
    t++;
    ui_m[t] = ui;
    if (en) bcnt = (bcnt + 1) % 256;
    uo_m[t] = 8'(bcnt ^ (bcnt >> 1));
    l = 1'b0;
    lat = 0;
    for (int k = 7; k >= 0; k--)
      if (ui_at(t - 2) == uo_at(t - 2 - k)) begin
        l = 1'b1;
        lat = k;
      end
    if ($countones(ui_at(t - 2) ^ ui_at(t - 3)) > 1 && err_m < 15) err_m++;
    uo_d[t] = bus.uo_out;
    chk("uo_out", 32'(bus.uo_out), 32'(uo_m[t]));
    chk("status", 32'(bus.uio_out), 32'({l, 4'(err_m), 3'(lat)}));
  endtask
  // loop back the DUT output through d extra cycles of delay
  task automatic lb(input int n, input int d, input logic en);
    repeat (n) cyc(t - d >= 0 ? uo_d[t - d] : 8'h00, en);
  endtask
  task automatic restart();
    t = 0;
    bcnt = 0;
    err_m = 0;
    uo_m[0] = 8'h00;
    ui_m[0] = 8'h00;
    uo_d[0] = 8'h00;
  endtask
  initial begin
    seq_tab = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C};
    rst_n = 1'b0;
    bus.ena = 1'b0;
    bus.ui_in = 8'h00;
    bus.uio_in = 8'hA5;
    restart();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uo", 32'(bus.uo_out), 32'h00);
    chk("rst_uio", 32'(bus.uio_out), 32'h00);
    chk("uio_oe", 32'(bus.uio_oe), 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lb(1, 0, 1'b1);
      chk("seq", 32'(bus.uo_out), 32'(seq_tab[i]));
    end
    chk("lb_lock", 32'(bus.uio_out[7]), 32'd1);
    chk("lb_lat", 32'(bus.uio_out[2:0]), 32'd1);
    lb(300, 0, 1'b1);
    lb(40, 2, 1'b1);
    chk("lb_lat3", 32'(bus.uio_out[2:0]), 32'd3);
    lb(10, 0, 1'b0);
    repeat (10) cyc(8'h55, 1'b1);
    repeat (20) begin
      if ($urandom_range(0, 1) == 0) repeat (3) cyc(8'($urandom), $urandom_range(0, 3) != 0);
      else lb(int'($urandom_range(3, 12)), int'($urandom_range(0, 7)), $urandom_range(0, 4) != 0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_uo", 32'(bus.uo_out), 32'h00);
    chk("async_uio", 32'(bus.uio_out), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    restart();
    repeat (3) cyc(8'h00, 1'b1);
    cyc(8'h03, 1'b1);
    repeat (2) cyc(8'h03, 1'b1);
    chk("err_one", 32'(bus.uio_out[6:3]), 32'd1);
    repeat (20) begin
      cyc(8'h00, 1'b1);
      cyc(8'h03, 1'b1);
    end
    repeat (4) cyc(8'h03, 1'b1);
    chk("err_sat", 32'(bus.uio_out[6:3]), 32'd15);
    lb(20, 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
